fdiv_post: RTL

- Two-stage pipelined post-processing stage directly downstream of the combinational divider fdiv.
- Takes the divider's raw quotient together with the original operands. Applies IEEE-754 special-case handling: NaN, infinity, zero, divide-by-zero, and exponent overflow/underflow (denormals flushed to zero).
- Produces the final result plus exception flags behind a valid/ready handshake.
- Holds sticky exception flags for the surrounding FPU.

---
 rtl/fdiv_pkg.sv | 38 +++
 rtl/fp_classify.sv | 24 ++
 rtl/fdiv_post.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared widths, constants and types for the fdiv post-processing stage
package fdiv_pkg;

  function automatic int exp_len_of(input int n);
    return (n == 64) ? 11 : 8;
  endfunction

  function automatic int man_len_of(input int n);
    return (n == 64) ? 52 : 23;
  endfunction

  function automatic int bias_of(input int n);
    return (1 << (exp_len_of(n) - 1)) - 1;
  endfunction

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  // Canonical quiet NaN, right-aligned in 64 bits
  function automatic logic [63:0] qnan_of(input int n);
    return (n == 64) ? QNAN64 : {32'h0, QNAN32};
  endfunction

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - classify an IEEE magnitude as zero (incl. denormal), inf or nan
module fp_classify
  import fdiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-2:0] mag,
  output fp_class_t    cls
);

  localparam int EXP_LEN = exp_len_of(N);
  localparam int MAN_LEN = man_len_of(N);

  logic [EXP_LEN-1:0] e;
  logic [MAN_LEN-1:0] m;

  assign e = mag[N-2 -: EXP_LEN];
  assign m = mag[MAN_LEN-1:0];

  assign cls.zero = (e == '0);
  assign cls.inf  = (&e) && (m == '0);
  assign cls.nan  = (&e) && (m != '0);

endmodule

// File: rtl/fdiv_post.sv
// rtl/fdiv_post.sv - two-stage IEEE special-case and range fixup after the fdiv quotient
module fdiv_post
  import fdiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [4:0]   out_flags,
  output logic [4:0]   sticky_flags,
  input  logic         clr_flags
);

  localparam int EXP_LEN = exp_len_of(N);
  localparam int MAN_LEN = man_len_of(N);
  localparam int BIAS    = bias_of(N);
  localparam int EW      = EXP_LEN + 2;
  localparam int MAX_EXP = (1 << EXP_LEN) - 2;
  localparam logic [63:0] QNAN_W = qnan_of(N);

  logic               s1_valid, s2_valid;
  logic               s1_adv, in_hs, out_hs;
  fp_class_t          ca, cb, s1_ca, s1_cb;
  logic               s1_sign;
  logic signed [EW-1:0] e_w, s1_ew;
  logic [N-2:0]       s1_q;
  logic [EXP_LEN-1:0] ea, eb;
  logic [MAN_LEN-1:0] ma, mb;
  logic               adj;
  logic [N-1:0]       res;
  fp_flags_t          fl;
  logic               unused_q_msb;

  assign unused_q_msb = q[N-1];

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_hs    = s2_valid && out_ready;

  fp_classify #(.N(N)) u_cls_a (.mag(a[N-2:0]), .cls(ca));
  fp_classify #(.N(N)) u_cls_b (.mag(b[N-2:0]), .cls(cb));

  assign ea  = a[N-2 -: EXP_LEN];
  assign eb  = b[N-2 -: EXP_LEN];
  assign ma  = a[MAN_LEN-1:0];
  assign mb  = b[MAN_LEN-1:0];
  // Quotient mantissa below 1.0 costs one exponent step
  assign adj = (ma < mb);
  assign e_w = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + $signed(EW'(BIAS)) - $signed(EW'(adj));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ca    <= '0;
      s1_cb    <= '0;
      s1_sign  <= 1'b0;
      s1_ew    <= '0;
      s1_q     <= '0;
    end else if (in_hs) begin
      s1_valid <= 1'b1;
      s1_ca    <= ca;
      s1_cb    <= cb;
      s1_sign  <= a[N-1] ^ b[N-1];
      s1_ew    <= e_w;
      s1_q     <= q[N-2:0];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    res = {s1_sign, s1_q};
    fl  = '0;
    if (s1_ca.nan || s1_cb.nan || (s1_ca.zero && s1_cb.zero) || (s1_ca.inf && s1_cb.inf)) begin
      res   = QNAN_W[N-1:0];
      fl.nv = 1'b1;
    end else if (s1_ca.inf) begin
      res = {s1_sign, {EXP_LEN{1'b1}}, {MAN_LEN{1'b0}}};
    end else if (s1_cb.inf) begin
      res = {s1_sign, {(N-1){1'b0}}};
    end else if (s1_cb.zero) begin
      res   = {s1_sign, {EXP_LEN{1'b1}}, {MAN_LEN{1'b0}}};
      fl.dz = 1'b1;
    end else if (s1_ca.zero) begin
      res = {s1_sign, {(N-1){1'b0}}};
    end else if (s1_ew > $signed(EW'(MAX_EXP))) begin
      res   = {s1_sign, {EXP_LEN{1'b1}}, {MAN_LEN{1'b0}}};
      fl.of = 1'b1;
      fl.nx = 1'b1;
    end else if (s1_ew < $signed(EW'(1))) begin
      res   = {s1_sign, {(N-1){1'b0}}};
      fl.uf = 1'b1;
      fl.nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out       <= '0;
      out_flags <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out       <= res;
        out_flags <= fl;
      end
    end
  end

  // Clear takes effect before the same-cycle handshake's flags are merged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (clr_flags) begin
      sticky_flags <= out_hs ? out_flags : 5'b0;
    end else if (out_hs) begin
      sticky_flags <= sticky_flags | out_flags;
    end
  end

endmodule
